// File: rtl/uart_tfifo_ext.sv
// UART transmit FIFO: distributed RAM with a show-ahead head, boundary-safe push/pop,
// sticky overrun/underrun, a threshold flag for the TX interrupt and a high-water tracker.
module uart_tfifo_ext #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    input  logic                      push,
    input  logic                      pop,
    input  logic [FIFO_WIDTH-1:0]     data_in,
    input  logic [FIFO_COUNTER_W-1:0] level,
    output logic [FIFO_WIDTH-1:0]     data_out,
    output logic [FIFO_COUNTER_W-1:0] count,
    output logic                      empty,
    output logic                      full,
    output logic                      level_hit,
    output logic                      overrun,
    output logic                      underrun,
    output logic [FIFO_COUNTER_W-1:0] high_water
);

    localparam logic [FIFO_COUNTER_W-1:0] DEPTH_C = FIFO_COUNTER_W'(FIFO_DEPTH);
    localparam logic [FIFO_POINTER_W-1:0] PTR_ONE = FIFO_POINTER_W'(1);
    localparam logic [FIFO_COUNTER_W-1:0] CNT_ONE = FIFO_COUNTER_W'(1);

    logic [FIFO_WIDTH-1:0]     mem [FIFO_DEPTH];

    logic [FIFO_POINTER_W-1:0] top_q, top_d;
    logic [FIFO_POINTER_W-1:0] bottom_q, bottom_d;
    logic [FIFO_COUNTER_W-1:0] count_q, count_d;
    logic [FIFO_COUNTER_W-1:0] high_water_q, high_water_d;
    logic                      overrun_q, overrun_d;
    logic                      underrun_q, underrun_d;

    logic empty_w;
    logic full_w;
    logic wr_en;
    logic rd_en;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);

    // A push into a full FIFO still succeeds when a pop frees the head slot in the same edge;
    // a pop against an empty FIFO is never accepted, even alongside a push.
    assign wr_en = push && (!full_w || pop) && !fifo_reset;
    assign rd_en = pop && !empty_w && !fifo_reset;

    always_comb begin
        top_d        = top_q;
        bottom_d     = bottom_q;
        count_d      = count_q;
        high_water_d = high_water_q;
        overrun_d    = overrun_q;
        underrun_d   = underrun_q;

        if (reset_status) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end

        if (fifo_reset) begin
            top_d        = '0;
            bottom_d     = '0;
            count_d      = '0;
            high_water_d = '0;
        end else begin
            if (wr_en) begin
                top_d = top_q + PTR_ONE;
            end
            if (rd_en) begin
                bottom_d = bottom_q + PTR_ONE;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + CNT_ONE;
            end else if (rd_en && !wr_en) begin
                count_d = count_q - CNT_ONE;
            end

            if (push && !pop && full_w) begin
                overrun_d = 1'b1;
            end
            if (pop && empty_w) begin
                underrun_d = 1'b1;
            end

            if (count_d > high_water_q) begin
                high_water_d = count_d;
            end
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            top_q        <= '0;
            bottom_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            top_q        <= top_d;
            bottom_q     <= bottom_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
        end
    end

    // Storage is deliberately not reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[top_q] <= data_in;
        end
    end

    assign data_out   = mem[bottom_q];
    assign count      = count_q;
    assign empty      = empty_w;
    assign full       = full_w;
    assign level_hit  = (count_q <= level);
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;
    assign high_water = high_water_q;

endmodule

// File: tb/tb_uart_tfifo_ext.sv
// Directed bench for uart_tfifo_ext: a queue-based reference model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_uart_tfifo_ext;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       fifo_reset = 1'b0;
    logic       reset_status = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [4:0] level = 5'd4;
    logic [7:0] data_out;
    logic [4:0] count;
    logic       empty, full, level_hit, overrun, underrun;
    logic [4:0] high_water;

    int n_cmp = 0;
    int n_err = 0;

    uart_tfifo_ext dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .fifo_reset(fifo_reset), .reset_status(reset_status),
        .push(push), .pop(pop), .data_in(data_in), .level(level),
        .data_out(data_out), .count(count), .empty(empty), .full(full),
        .level_hit(level_hit), .overrun(overrun), .underrun(underrun), .high_water(high_water)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO as a plain queue of bytes.
    byte unsigned m_q[$];
    bit           m_ovr = 0;
    bit           m_und = 0;
    int           m_hw  = 0;

    always @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_q.delete();
            m_ovr = 0;
            m_und = 0;
            m_hw  = 0;
        end else begin
            if (reset_status) begin
                m_ovr = 0;
                m_und = 0;
            end
            if (fifo_reset) begin
                m_q.delete();
                m_hw = 0;
            end else begin
                if (push && pop) begin
                    if (m_q.size() == 0) begin
                        m_und = 1;
                    end else begin
                        void'(m_q.pop_front());
                    end
                    m_q.push_back(data_in);
                end else if (push) begin
                    if (m_q.size() == 16) m_ovr = 1;
                    else m_q.push_back(data_in);
                end else if (pop) begin
                    if (m_q.size() == 0) m_und = 1;
                    else void'(m_q.pop_front());
                end
                if (m_q.size() > m_hw) m_hw = m_q.size();
            end
        end
    end

    always @(negedge clk) begin
        chk("m_count", count, m_q.size());
        chk("m_empty", empty, m_q.size() == 0);
        chk("m_full", full, m_q.size() == 16);
        chk("m_level_hit", level_hit, m_q.size() <= int'(level));
        chk("m_overrun", overrun, m_ovr);
        chk("m_underrun", underrun, m_und);
        chk("m_high_water", high_water, m_hw);
        if (m_q.size() != 0) chk("m_data_out", data_out, m_q[0]);
    end

    // Drive one cycle's inputs just after the falling edge, return just after the next one.
    task automatic step(input bit pu, input bit po, input logic [7:0] d,
                        input bit rs = 0, input bit fr = 0);
        push = pu; pop = po; data_in = d; reset_status = rs; fifo_reset = fr;
        @(negedge clk); #1;
        push = 0; pop = 0; reset_status = 0; fifo_reset = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && count != 0; i++) step(0, 1, 8'h00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level_hit", level_hit, 1);
        chk("rst_high_water", high_water, 0);
        wb_rst_i = 0;
        @(negedge clk); #1;

        // 1: single byte through
        step(1, 0, 8'hA5);
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        chk("t1_data", data_out, 8'hA5);
        chk("t1_hw", high_water, 1);
        step(0, 1, 8'h00);
        chk("t1_empty_after", empty, 1);
        chk("t1_underrun", underrun, 0);

        // 2: fill, overrun, drain
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
        chk("t2_full", full, 1);
        chk("t2_count", count, 16);
        step(1, 0, 8'hFF);
        chk("t2_overrun", overrun, 1);
        chk("t2_count_ovr", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", data_out, 8'(i));
            step(0, 1, 8'h00);
        end
        chk("t2_hw", high_water, 16);
        step(0, 0, 8'h00, 1);
        chk("t2_ovr_clr", overrun, 0);

        // 3: pointer wrap
        for (int i = 0; i < 10; i++) step(1, 0, 8'h20 + 8'(i));
        drain();
        for (int i = 0; i < 12; i++) step(1, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 12; i++) begin
            chk("t3_order", data_out, 8'h30 + 8'(i));
            step(0, 1, 8'h00);
        end
        chk("t3_count", count, 0);

        // 4a: push+pop on empty
        step(1, 1, 8'h55);
        chk("t4a_count", count, 1);
        chk("t4a_data", data_out, 8'h55);
        chk("t4a_underrun", underrun, 1);
        step(0, 1, 8'h00, 1);
        chk("t4a_und_clr", underrun, 0);

        // 4b: push+pop on full
        for (int i = 0; i < 16; i++) step(1, 0, 8'h40 + 8'(i));
        step(1, 1, 8'h99);
        chk("t4b_count", count, 16);
        chk("t4b_head", data_out, 8'h41);
        chk("t4b_overrun", overrun, 0);
        drain();

        // 4c: push+pop mid-fill
        for (int i = 0; i < 5; i++) step(1, 0, 8'h60 + 8'(i));
        step(1, 1, 8'h77);
        chk("t4c_count", count, 5);
        chk("t4c_head", data_out, 8'h61);
        drain();

        // 5: threshold
        level = 5'd4;
        for (int i = 0; i < 4; i++) step(1, 0, 8'h80 + 8'(i));
        chk("t5_hit4", level_hit, 1);
        step(1, 0, 8'h84);
        chk("t5_hit5", level_hit, 0);
        step(0, 1, 8'h00);
        chk("t5_hit_back", level_hit, 1);
        drain();

        // 6a: flush with a coincident push
        step(0, 1, 8'h00);
        chk("t6a_und_set", underrun, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 8'hC0 + 8'(i));
        step(1, 0, 8'hEE, 0, 1);
        chk("t6a_count", count, 0);
        chk("t6a_hw", high_water, 0);
        chk("t6a_empty", empty, 1);
        chk("t6a_underrun", underrun, 1);
        chk("t6a_overrun", overrun, 0);

        // 6b: asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) step(1, 0, 8'hD0 + 8'(i));
        @(posedge clk); #2;
        wb_rst_i = 1;
        #1;
        chk("t6b_count", count, 0);
        chk("t6b_empty", empty, 1);
        chk("t6b_full", full, 0);
        chk("t6b_level_hit", level_hit, 1);
        chk("t6b_underrun", underrun, 0);
        chk("t6b_overrun", overrun, 0);
        chk("t6b_hw", high_water, 0);
        @(negedge clk); #1;
        wb_rst_i = 0;
        step(1, 0, 8'h3C);
        chk("t6b_after", data_out, 8'h3C);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
